// File: rtl/bh_io_unit.sv
// -----------------------------------------------------------------------------
// bh_io_unit
// Buffered character I/O unit for the brainhack core. It serves the '.'
// (output) and ',' (input) instructions through two independent circular
// FIFOs:
//   - output FIFO: core -> external transmitter (valid/ready on the tx side)
//   - input FIFO : external receiver -> core   (valid/ready on the rx side)
// The core sees a combinational ack per request. It sees o_stall whenever a
// request cannot be served in the current cycle.
//
// Optional feature: define BH_IO_EOF_EN to add a sticky end-of-stream latch.
// The latch is set by i_rx_eof. Once it is set and the input FIFO is empty,
// an input request completes immediately with EOF_VALUE.
//
// Parameters:
//   DATA_WIDTH  width of one character (matches tape data width)
//   DEPTH_LOG2  log2 of each FIFO depth (1..8)
//   EOF_VALUE   character returned on input after end-of-stream
//
// Ports:
//   i_clock, i_reset             clock, async active-high reset
//   i_out_req/i_out_data         core '.' request and the cell value
//   o_out_ack                    output request accepted this cycle
//   i_in_req                     core ',' request
//   o_in_data/o_in_ack           character for the tape, valid with ack
//   o_stall                      core must hold and re-present its request
//   o_tx_valid/o_tx_data         head of the output FIFO
//   i_tx_ready                   sink takes the head
//   i_rx_valid/i_rx_data         incoming character offer
//   o_rx_ready                   input FIFO not full
//   i_rx_eof                     end of input stream (BH_IO_EOF_EN only)
//   o_out_count/o_in_count       FIFO occupancies
// -----------------------------------------------------------------------------
module bh_io_unit #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH_LOG2 = 4,
  parameter logic [DATA_WIDTH-1:0] EOF_VALUE  = '0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_out_req,
  input  logic [DATA_WIDTH-1:0] i_out_data,
  output logic                  o_out_ack,
  input  logic                  i_in_req,
  output logic [DATA_WIDTH-1:0] o_in_data,
  output logic                  o_in_ack,
  output logic                  o_stall,
  output logic                  o_tx_valid,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  input  logic                  i_tx_ready,
  input  logic                  i_rx_valid,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  output logic                  o_rx_ready,
  input  logic                  i_rx_eof,
  output logic [DEPTH_LOG2:0]   o_out_count,
  output logic [DEPTH_LOG2:0]   o_in_count
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] L_FULL    = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] L_CNT_ONE = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] L_PTR_ONE = DEPTH_LOG2'(1);

  // Storage (deliberately not reset; pointers/counts define validity)
  logic [DATA_WIDTH-1:0] r_out_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_in_mem  [0:DEPTH-1];

  logic [DEPTH_LOG2-1:0] r_out_wptr;
  logic [DEPTH_LOG2-1:0] r_out_rptr;
  logic [DEPTH_LOG2:0]   r_out_count;
  logic [DEPTH_LOG2-1:0] r_in_wptr;
  logic [DEPTH_LOG2-1:0] r_in_rptr;
  logic [DEPTH_LOG2:0]   r_in_count;

  logic w_out_full;
  logic w_out_empty;
  logic w_out_push;
  logic w_out_pop;
  logic w_in_full;
  logic w_in_empty;
  logic w_rx_push;
  logic w_in_pop;
  logic w_in_ack;

  // Full/empty come from the registered counts only, so a push into a full
  // FIFO is refused even when the same cycle pops (no pass-through).
  assign w_out_full  = (r_out_count == L_FULL);
  assign w_out_empty = (r_out_count == '0);
  assign w_in_full   = (r_in_count == L_FULL);
  assign w_in_empty  = (r_in_count == '0);

  assign w_out_push = i_out_req & ~w_out_full;
  assign w_out_pop  = ~w_out_empty & i_tx_ready;
  assign w_rx_push  = i_rx_valid & ~w_in_full;
  // A buffered character is consumed only when one exists; an EOF ack pops nothing.
  assign w_in_pop   = i_in_req & ~w_in_empty;

`ifdef BH_IO_EOF_EN
  logic r_eof;

  // Sticky end-of-stream latch, cleared only by reset
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_eof <= 1'b0;
    end else if (i_rx_eof) begin
      r_eof <= 1'b1;
    end
  end

  assign w_in_ack = i_in_req & (~w_in_empty | r_eof);
`else
  logic w_unused_rx_eof;
  assign w_unused_rx_eof = i_rx_eof;
  assign w_in_ack        = w_in_pop;
`endif

  assign o_out_ack   = w_out_push;
  assign o_tx_valid  = ~w_out_empty;
  assign o_tx_data   = r_out_mem[r_out_rptr];
  assign o_rx_ready  = ~w_in_full;
  assign o_in_ack    = w_in_ack;
  assign o_stall     = (i_out_req & ~w_out_push) | (i_in_req & ~w_in_ack);
  assign o_out_count = r_out_count;
  assign o_in_count  = r_in_count;

  // Character to the tape: buffered head first, EOF_VALUE only on an empty-FIFO ack
  always_comb begin
    o_in_data = '0;
    if (w_in_pop) begin
      o_in_data = r_in_mem[r_in_rptr];
    end else if (w_in_ack) begin
      o_in_data = EOF_VALUE;
    end else begin
      o_in_data = '0;
    end
  end

  // Output FIFO storage write
  always_ff @(posedge i_clock) begin
    if (w_out_push) begin
      r_out_mem[r_out_wptr] <= i_out_data;
    end
  end

  // Input FIFO storage write
  always_ff @(posedge i_clock) begin
    if (w_rx_push) begin
      r_in_mem[r_in_wptr] <= i_rx_data;
    end
  end

  // Output FIFO pointers and occupancy
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_out_wptr  <= '0;
      r_out_rptr  <= '0;
      r_out_count <= '0;
    end else begin
      if (w_out_push) begin
        r_out_wptr <= r_out_wptr + L_PTR_ONE;
      end
      if (w_out_pop) begin
        r_out_rptr <= r_out_rptr + L_PTR_ONE;
      end
      case ({w_out_push, w_out_pop})
        2'b10:   r_out_count <= r_out_count + L_CNT_ONE;
        2'b01:   r_out_count <= r_out_count - L_CNT_ONE;
        default: r_out_count <= r_out_count;
      endcase
    end
  end

  // Input FIFO pointers and occupancy
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_in_wptr  <= '0;
      r_in_rptr  <= '0;
      r_in_count <= '0;
    end else begin
      if (w_rx_push) begin
        r_in_wptr <= r_in_wptr + L_PTR_ONE;
      end
      if (w_in_pop) begin
        r_in_rptr <= r_in_rptr + L_PTR_ONE;
      end
      case ({w_rx_push, w_in_pop})
        2'b10:   r_in_count <= r_in_count + L_CNT_ONE;
        2'b01:   r_in_count <= r_in_count - L_CNT_ONE;
        default: r_in_count <= r_in_count;
      endcase
    end
  end

endmodule

// File: tb/tb_bh_io_unit.sv
// -----------------------------------------------------------------------------
// tb_bh_io_unit
// Self-checking bench for bh_io_unit (default parameters). A queue-based
// reference model predicts acks, stall, FIFO heads and occupancies each cycle.
// Directed sequences are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_bh_io_unit;

  localparam int DW    = 8;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] EOF_V = 8'h00;

  logic          i_clock;
  logic          i_reset;
  logic          i_out_req;
  logic [DW-1:0] i_out_data;
  logic          o_out_ack;
  logic          i_in_req;
  logic [DW-1:0] o_in_data;
  logic          o_in_ack;
  logic          o_stall;
  logic          o_tx_valid;
  logic [DW-1:0] o_tx_data;
  logic          i_tx_ready;
  logic          i_rx_valid;
  logic [DW-1:0] i_rx_data;
  logic          o_rx_ready;
  logic          i_rx_eof;
  logic [DL2:0]  o_out_count;
  logic [DL2:0]  o_in_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DW-1:0] m_out_q[$];
  logic [DW-1:0] m_in_q[$];
  bit            m_eof = 1'b0;

  bh_io_unit #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2), .EOF_VALUE(EOF_V)) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_out_req  (i_out_req),
    .i_out_data (i_out_data),
    .o_out_ack  (o_out_ack),
    .i_in_req   (i_in_req),
    .o_in_data  (o_in_data),
    .o_in_ack   (o_in_ack),
    .o_stall    (o_stall),
    .o_tx_valid (o_tx_valid),
    .o_tx_data  (o_tx_data),
    .i_tx_ready (i_tx_ready),
    .i_rx_valid (i_rx_valid),
    .i_rx_data  (i_rx_data),
    .o_rx_ready (o_rx_ready),
    .i_rx_eof   (i_rx_eof),
    .o_out_count(o_out_count),
    .o_in_count (o_in_count)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare against the
  // model, then apply the model's transfers at the rising edge.
  task automatic cycle(input bit oreq, input logic [DW-1:0] odata, input bit ireq,
                       input bit txr, input bit rxv, input logic [DW-1:0] rxd, input bit eof);
    bit e_out_ack, e_tx_valid, e_rx_ready, e_in_ack, e_stall;
    logic [DW-1:0] e_in_data;
    i_out_req  = oreq;
    i_out_data = odata;
    i_in_req   = ireq;
    i_tx_ready = txr;
    i_rx_valid = rxv;
    i_rx_data  = rxd;
    i_rx_eof   = eof;
    #1;
    e_out_ack  = oreq && (m_out_q.size() < DEPTH);
    e_tx_valid = (m_out_q.size() > 0);
    e_rx_ready = (m_in_q.size() < DEPTH);
    e_in_ack   = ireq && ((m_in_q.size() > 0) || m_eof);
    e_in_data  = !e_in_ack ? 8'h00 : ((m_in_q.size() > 0) ? m_in_q[0] : EOF_V);
    e_stall    = (oreq && !e_out_ack) || (ireq && !e_in_ack);
    check_value("out_ack",   32'(o_out_ack),   32'(e_out_ack));
    check_value("in_ack",    32'(o_in_ack),    32'(e_in_ack));
    check_value("in_data",   32'(o_in_data),   32'(e_in_data));
    check_value("stall",     32'(o_stall),     32'(e_stall));
    check_value("tx_valid",  32'(o_tx_valid),  32'(e_tx_valid));
    check_value("rx_ready",  32'(o_rx_ready),  32'(e_rx_ready));
    check_value("out_count", 32'(o_out_count), 32'(m_out_q.size()));
    check_value("in_count",  32'(o_in_count),  32'(m_in_q.size()));
    if (e_tx_valid) check_value("tx_data", 32'(o_tx_data), 32'(m_out_q[0]));
    @(posedge i_clock);
    if (e_tx_valid && txr) void'(m_out_q.pop_front());
    if (e_out_ack) m_out_q.push_back(odata);
    if (e_in_ack && (m_in_q.size() > 0)) void'(m_in_q.pop_front());
    if (rxv && e_rx_ready) m_in_q.push_back(rxd);
`ifdef BH_IO_EOF_EN
    if (eof) m_eof = 1'b1;
`endif
    @(negedge i_clock);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check_value({tag, "_out_count"}, 32'(o_out_count), 32'd0);
    check_value({tag, "_in_count"},  32'(o_in_count),  32'd0);
    check_value({tag, "_tx_valid"},  32'(o_tx_valid),  32'd0);
    check_value({tag, "_rx_ready"},  32'(o_rx_ready),  32'd1);
    check_value({tag, "_stall"},     32'(o_stall),     32'd0);
    check_value({tag, "_in_data"},   32'(o_in_data),   32'd0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p_out, p_in, p_tx, p_rx;
    i_reset = 1'b1; i_out_req = 1'b0; i_out_data = '0; i_in_req = 1'b0;
    i_tx_ready = 1'b0; i_rx_valid = 1'b0; i_rx_data = '0; i_rx_eof = 1'b0;
    repeat (2) @(negedge i_clock);
    #1;
    check_reset_state("reset");
    i_reset = 1'b0;
    @(negedge i_clock);

    // 1: single output, visible one cycle later
    cycle(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_value("t1_tx_data", 32'(o_tx_data), 32'h41);
    idle(1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // 2: fill output FIFO, refuse while full even with a pop, then drain
    for (int k = 0; k < 16; k++) cycle(1'b1, 8'(k), 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_value("t2_full_count", 32'(o_out_count), 32'd16);
    for (int k = 0; k < 17; k++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // 3: input request on empty stalls until a character arrives
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h7A, 1'b0);
    check_value("t3_data", 32'(o_in_data), 32'h7A);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    idle(1);

    // 4: fill input FIFO past full, then stream with the core consuming
    for (int k = 0; k < 18; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'(8'h80 + k), 1'b0);
    for (int k = 0; k < 20; k++) cycle(1'b0, 8'h00, (k >= 3), 1'b0, 1'b1, 8'(8'hC0 + k), 1'b0);
    for (int k = 0; k < 20; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    // 5: asynchronous reset with 5 characters in each FIFO
    for (int k = 0; k < 5; k++) cycle(1'b1, 8'(8'h50 + k), 1'b0, 1'b0, 1'b1, 8'(8'h60 + k), 1'b0);
    check_value("t5_pre_out", 32'(o_out_count), 32'd5);
    check_value("t5_pre_in",  32'(o_in_count),  32'd5);
    #2 i_reset = 1'b1;
    #1;
    check_reset_state("t5_async");
    @(negedge i_clock);
    i_reset = 1'b0;
    m_out_q.delete();
    m_in_q.delete();
    idle(2);

    // Randomized phase with varying traffic mixes
    for (int ph = 0; ph < 20; ph++) begin
      p_out = $urandom_range(0, 100);
      p_in  = $urandom_range(0, 100);
      p_tx  = $urandom_range(0, 100);
      p_rx  = $urandom_range(0, 100);
      for (int k = 0; k < 80; k++) begin
        cycle($urandom_range(0, 99) < p_out, 8'($urandom), $urandom_range(0, 99) < p_in,
              $urandom_range(0, 99) < p_tx, $urandom_range(0, 99) < p_rx, 8'($urandom), 1'b0);
      end
    end

    // 6: end-of-stream; buffered characters first, then EOF or stall
    for (int k = 0; k < 20; k++) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h31, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h32, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
